dense_seq_ctrl: RTL

- Sequencer for the DENSE compute mode; produces the dense-side buffer M1 control and PE-array control bundle, plus aybz_azby_dense.
- For each of out_len output neurons: streams in_len input words from the source buffer into the PE array with MAC enabled, waits for the MAC pipeline to drain, then writes one result word through the NL stage into the destination buffer.
- Sits beside the conv/pool sequencers; its outputs feed the top-level buffer/PE-array mux when comp_sel = 3'b010.

---
 rtl/dense_pkg.sv | 28 ++
 rtl/dense_delay_line.sv | 42 ++++
 rtl/dense_seq_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dense_pkg.sv
// dense_pkg
//   Shared definitions for the DENSE compute-mode sequencer:
//   - dense_state_t : sequencer state encoding
//   - COMP_*        : comp_sel encodings used by the top-level buffer/PE mux
//   - NL_*          : non-linearity type codes carried on nl_type
package dense_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WRITE = 3'd4,
    ST_NEXT  = 3'd5,
    ST_DONE  = 3'd6
  } dense_state_t;

  localparam logic [2:0] COMP_IDLE  = 3'b000;
  localparam logic [2:0] COMP_CONV  = 3'b001;
  localparam logic [2:0] COMP_DENSE = 3'b010;
  localparam logic [2:0] COMP_POOL  = 3'b011;

  localparam logic [1:0] NL_NONE    = 2'd0;
  localparam logic [1:0] NL_RELU    = 2'd1;
  localparam logic [1:0] NL_SIGMOID = 2'd2;
  localparam logic [1:0] NL_TANH    = 2'd3;

endpackage

// File: rtl/dense_delay_line.sv
// dense_delay_line
//   Shift register that delays a 1-bit strobe by DEPTH cycles. Used to turn
//   the buffer read strobe into the PE MAC enable so the enable lines up with
//   the data arriving from the buffer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous flush of every stage (used on abort)
//   din        : strobe in
//   dout       : strobe delayed by DEPTH cycles
module dense_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic din,
  output logic dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      // Zero depth: combinational pass-through, still honouring the flush.
      assign dout = din & ~clear;
    end else begin : g_shift
      logic [DEPTH-1:0] stages;

      // Stage 0 takes the new strobe; the oldest stage drives the output.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stages <= '0;
        end else if (clear) begin
          stages <= '0;
        end else begin
          stages <= (stages << 1) | DEPTH'(din);
        end
      end

      assign dout = stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/dense_seq_ctrl.sv
// dense_seq_ctrl
//   Sequencer for the DENSE compute mode. For each of out_len output neurons
//   it clears the accumulator, streams in_len words from the source buffer
//   into the PE array, waits for the MAC pipeline to drain, then writes one
//   result word through the NL stage into the destination buffer.
//   Optional build macro: DENSE_SEQ_CTRL_PERF_EN adds cycle_cnt/stall_flag.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, abort          : start pulse (IDLE only), synchronous abort
//   src_sel               : 0 read buf1/write buf2, 1 read buf2/write buf1
//   in_len, out_len       : words per neuron, neuron count
//   in_base, out_base     : source / destination start addresses
//   nl_type_cfg           : non-linearity type
//   busy, done            : activity flag, one-cycle completion pulse
//   buf{1,2}_{r,w}_{en,addr} : M1 buffer port controls
//   mac_enable, line_buffer_reset, shifting_filter, nl_enable, nl_type :
//                           PE-array control bundle
//   aybz_azby_dense       : inverted src_sel latched at start
//   cycle_cnt, stall_flag : only with DENSE_SEQ_CTRL_PERF_EN
// RD_LAT + MAC_LAT must be at least 1.
module dense_seq_ctrl
  import dense_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int CNT_W   = 12,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              src_sel,
  input  logic [CNT_W-1:0]  in_len,
  input  logic [CNT_W-1:0]  out_len,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  input  logic [1:0]        nl_type_cfg,
  output logic              busy,
  output logic              done,
  output logic              buf1_r_en,
  output logic              buf1_w_en,
  output logic              buf2_r_en,
  output logic              buf2_w_en,
  output logic [ADDR_W-1:0] buf1_r_addr,
  output logic [ADDR_W-1:0] buf1_w_addr,
  output logic [ADDR_W-1:0] buf2_r_addr,
  output logic [ADDR_W-1:0] buf2_w_addr,
  output logic              mac_enable,
  output logic              line_buffer_reset,
  output logic              shifting_filter,
  output logic              nl_enable,
  output logic [1:0]        nl_type,
  output logic              aybz_azby_dense
`ifdef DENSE_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic              stall_flag
`endif
);

  localparam int DRAIN_LEN = RD_LAT + MAC_LAT;
  localparam int DRAIN_W   = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

  dense_state_t      state;
  logic [CNT_W-1:0]  in_len_q;
  logic [CNT_W-1:0]  out_len_q;
  logic [ADDR_W-1:0] in_base_q;
  logic [ADDR_W-1:0] out_base_q;
  logic              src_sel_q;
  logic [CNT_W-1:0]  rd_idx;
  logic [CNT_W-1:0]  nrn_idx;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [ADDR_W-1:0] rd_addr_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic              rd_strobe;
  logic              start_ok;

  assign start_ok = (state == ST_IDLE) && start && !abort;

  // Address of the word presented on the next read cycle: the base when
  // entering READ from CLR, otherwise one past the current index. Sums wrap
  // modulo 2^ADDR_W.
  assign rd_addr_nxt = (state == ST_CLR) ? in_base_q
                                         : in_base_q + ADDR_W'(rd_idx + CNT_W'(1));
  assign wr_addr_nxt = out_base_q + ADDR_W'(nrn_idx);

  // Main sequencer. Outputs are registered together with the state so each
  // control line is valid exactly in the cycle its state is occupied; all
  // strobes and addresses default to 0 every cycle, which also keeps the
  // unselected buffer ports at 0 and makes abort drop every enable at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      in_len_q          <= '0;
      out_len_q         <= '0;
      in_base_q         <= '0;
      out_base_q        <= '0;
      src_sel_q         <= 1'b0;
      rd_idx            <= '0;
      nrn_idx           <= '0;
      drain_cnt         <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      buf1_r_en         <= 1'b0;
      buf1_w_en         <= 1'b0;
      buf2_r_en         <= 1'b0;
      buf2_w_en         <= 1'b0;
      buf1_r_addr       <= '0;
      buf1_w_addr       <= '0;
      buf2_r_addr       <= '0;
      buf2_w_addr       <= '0;
      line_buffer_reset <= 1'b0;
      shifting_filter   <= 1'b0;
      nl_enable         <= 1'b0;
      nl_type           <= 2'd0;
      aybz_azby_dense   <= 1'b1;
    end else begin
      busy              <= 1'b0;
      done              <= 1'b0;
      buf1_r_en         <= 1'b0;
      buf1_w_en         <= 1'b0;
      buf2_r_en         <= 1'b0;
      buf2_w_en         <= 1'b0;
      buf1_r_addr       <= '0;
      buf1_w_addr       <= '0;
      buf2_r_addr       <= '0;
      buf2_w_addr       <= '0;
      line_buffer_reset <= 1'b0;
      shifting_filter   <= 1'b0;
      nl_enable         <= 1'b0;

      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              in_len_q        <= in_len;
              out_len_q       <= out_len;
              in_base_q       <= in_base;
              out_base_q      <= out_base;
              src_sel_q       <= src_sel;
              nl_type         <= nl_type_cfg;
              aybz_azby_dense <= ~src_sel;
              nrn_idx         <= '0;
              // An empty job skips straight to the completion pulse.
              if (in_len == '0 || out_len == '0) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                state             <= ST_CLR;
                busy              <= 1'b1;
                line_buffer_reset <= 1'b1;
              end
            end
          end

          ST_CLR: begin
            state       <= ST_READ;
            busy        <= 1'b1;
            rd_idx      <= '0;
            buf1_r_en   <= ~src_sel_q;
            buf2_r_en   <= src_sel_q;
            buf1_r_addr <= src_sel_q ? '0 : rd_addr_nxt;
            buf2_r_addr <= src_sel_q ? rd_addr_nxt : '0;
          end

          ST_READ: begin
            busy <= 1'b1;
            if (rd_idx == in_len_q - CNT_W'(1)) begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
            end else begin
              rd_idx      <= rd_idx + CNT_W'(1);
              buf1_r_en   <= ~src_sel_q;
              buf2_r_en   <= src_sel_q;
              buf1_r_addr <= src_sel_q ? '0 : rd_addr_nxt;
              buf2_r_addr <= src_sel_q ? rd_addr_nxt : '0;
            end
          end

          ST_DRAIN: begin
            busy <= 1'b1;
            if (drain_cnt == DRAIN_W'(DRAIN_LEN - 1)) begin
              state       <= ST_WRITE;
              nl_enable   <= 1'b1;
              buf1_w_en   <= src_sel_q;
              buf2_w_en   <= ~src_sel_q;
              buf1_w_addr <= src_sel_q ? wr_addr_nxt : '0;
              buf2_w_addr <= src_sel_q ? '0 : wr_addr_nxt;
            end else begin
              drain_cnt <= drain_cnt + DRAIN_W'(1);
            end
          end

          ST_WRITE: begin
            if (nrn_idx == out_len_q - CNT_W'(1)) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state           <= ST_NEXT;
              busy            <= 1'b1;
              shifting_filter <= 1'b1;
            end
          end

          ST_NEXT: begin
            state             <= ST_CLR;
            busy              <= 1'b1;
            line_buffer_reset <= 1'b1;
            nrn_idx           <= nrn_idx + CNT_W'(1);
          end

          ST_DONE: begin
            state <= ST_IDLE;
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // MAC enable is the read strobe shifted by the buffer read latency; abort
  // flushes it so the PE array stops in the same cycle as everything else.
  assign rd_strobe = buf1_r_en | buf2_r_en;

  dense_delay_line #(
    .DEPTH (RD_LAT)
  ) u_mac_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (abort),
    .din   (rd_strobe),
    .dout  (mac_enable)
  );

`ifdef DENSE_SEQ_CTRL_PERF_EN
  // Busy-cycle counter: restarts on an accepted start, saturates at all-ones
  // and simply holds once busy falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
    end else if (start_ok) begin
      cycle_cnt <= '0;
    end else if (busy && (cycle_cnt != '1)) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  assign stall_flag = 1'b0;
`else
  // Performance counter not built; start_ok only feeds that logic.
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule
